tx_iq_rate_buf: RTL and testbench

//  Consumes the dot11_tx baseband stream (result_i/q, valid/ready) and replays it to the DAC/DUC at a fixed

---
 rtl/tx_iq_pkg.sv | 31 +++
 rtl/tx_iq_rate_buf_if.sv | 12 +
 rtl/tx_iq_sync_fifo.sv | 50 +++++
 rtl/tx_iq_rate_buf.sv | 148 ++++++++++++++
 tb/tb_tx_iq_rate_buf.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_iq_pkg.sv
// Shared types, default parameters and the Q1.7 gain saturation helper for the TX IQ rate buffer.
package tx_iq_pkg;

    localparam int unsigned DATA_W_DEF     = 16;
    localparam int unsigned DEPTH_LOG2_DEF = 9;
    localparam int unsigned SAMPLE_DIV_DEF = 10;
    localparam int unsigned PREFILL_DEF    = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREFILL,
        ST_STREAM
    } state_t;

    // Scale a sample*gain product back by 2^7 (arithmetic) and clamp to a signed w-bit range.
    function automatic logic signed [31:0] sat_q17(input logic signed [47:0] prod, input int unsigned w);
        logic signed [47:0] sh;
        logic signed [47:0] hi;
        logic signed [47:0] lo;
        sh = prod >>> 7;
        hi = (48'sd1 <<< (w - 1)) - 48'sd1;
        lo = -(48'sd1 <<< (w - 1));
        if (sh > hi)
            return hi[31:0];
        else if (sh < lo)
            return lo[31:0];
        else
            return sh[31:0];
    endfunction

endpackage

// File: rtl/tx_iq_rate_buf_if.sv
// Baseband IQ input stream (valid/ready) from the dot11_tx generator into the rate buffer.
interface tx_iq_rate_buf_if #(
    parameter int unsigned DATA_W = 16
);
    logic              iq_valid;
    logic              iq_ready;
    logic [DATA_W-1:0] iq_i;
    logic [DATA_W-1:0] iq_q;

    modport master (output iq_valid, output iq_i, output iq_q, input iq_ready);
    modport slave  (input iq_valid, input iq_i, input iq_q, output iq_ready);
endinterface

// File: rtl/tx_iq_sync_fifo.sv
// Single-clock FIFO with registered read data (valid the cycle after pop) and an exact occupancy count.
module tx_iq_sync_fifo #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;

    assign full  = (level == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty = (level == '0);

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rd_data <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/tx_iq_rate_buf.sv
// Replays the bursty dot11_tx IQ stream at a fixed DAC sample rate with prefill and underrun flagging.
// Optional build macro TX_IQ_GAIN_EN adds a Q1.7 gain port and one saturating output pipeline stage.
module tx_iq_rate_buf
    import tx_iq_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int unsigned PREFILL    = PREFILL_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic                 frame_done,
    tx_iq_rate_buf_if.slave      iq,
    output logic                 dac_valid,
    output logic [DATA_W-1:0]    dac_i,
    output logic [DATA_W-1:0]    dac_q,
    output logic                 underrun,
    output logic                 busy,
    output logic                 tx_end,
    output logic [DEPTH_LOG2:0]  level
`ifdef TX_IQ_GAIN_EN
    ,
    input  logic [7:0]           gain
`endif
);
    localparam int unsigned          DIV_W       = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0]     DIV_LAST    = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [DEPTH_LOG2:0]  PREFILL_LVL = (DEPTH_LOG2 + 1)'(PREFILL);

    state_t                state_q, state_d;
    logic [2*DATA_W-1:0]   rd_data;
    logic                  full, empty, push, pop, strobe, last_pop;
    logic                  dac_valid_d, tx_end_d;
    logic                  done_seen_q, underrun_q, zero_q, dac_valid_q, tx_end_q;
    logic [DIV_W-1:0]      div_q;
    logic [DATA_W-1:0]     s_i, s_q;

    assign iq.iq_ready = !full;
    assign push        = iq.iq_valid && !full;

    tx_iq_sync_fifo #(
        .WIDTH      (2 * DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .wr_data ({iq.iq_i, iq.iq_q}),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:
                if (frame_start)
                    state_d = ST_PREFILL;
            ST_PREFILL:
                if (level >= PREFILL_LVL || (done_seen_q && !empty))
                    state_d = ST_STREAM;
                else if (done_seen_q)
                    state_d = ST_IDLE;
            ST_STREAM:
                if (strobe && done_seen_q && (empty || last_pop))
                    state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    // A pop with a concurrent push is never the final sample of the frame.
    always_comb begin
        strobe      = (state_q == ST_STREAM) && (div_q == DIV_LAST);
        pop         = strobe && !empty;
        last_pop    = pop && (level == (DEPTH_LOG2 + 1)'(1)) && !push;
        dac_valid_d = strobe && !(empty && done_seen_q);
        tx_end_d    = (strobe && done_seen_q && (empty || last_pop))
                   || (state_q == ST_PREFILL && done_seen_q && empty);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            done_seen_q <= 1'b0;
            underrun_q  <= 1'b0;
            div_q       <= '0;
            zero_q      <= 1'b1;
            dac_valid_q <= 1'b0;
            tx_end_q    <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && frame_start) begin
                done_seen_q <= 1'b0;
                underrun_q  <= 1'b0;
            end else begin
                if (state_q != ST_IDLE && frame_done)
                    done_seen_q <= 1'b1;
                if (strobe && empty && !done_seen_q)
                    underrun_q <= 1'b1;
            end
            div_q <= (state_q == ST_STREAM && !strobe) ? div_q + 1'b1 : '0;
            // zero_q masks the held FIFO read register: cleared by a real pop, set by an empty strobe or idling.
            if (strobe)
                zero_q <= empty;
            else if (state_q != ST_STREAM)
                zero_q <= 1'b1;
            dac_valid_q <= dac_valid_d;
            tx_end_q    <= tx_end_d;
        end
    end

    assign s_i      = zero_q ? '0 : rd_data[2*DATA_W-1:DATA_W];
    assign s_q      = zero_q ? '0 : rd_data[DATA_W-1:0];
    assign underrun = underrun_q;
    assign busy     = (state_q != ST_IDLE);

`ifdef TX_IQ_GAIN_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            dac_i     <= '0;
            dac_q     <= '0;
            dac_valid <= 1'b0;
            tx_end    <= 1'b0;
        end else begin
            dac_i     <= DATA_W'(sat_q17(48'(signed'(s_i)) * signed'(48'({1'b0, gain})), DATA_W));
            dac_q     <= DATA_W'(sat_q17(48'(signed'(s_q)) * signed'(48'({1'b0, gain})), DATA_W));
            dac_valid <= dac_valid_q;
            tx_end    <= tx_end_q;
        end
    end
`else
    assign dac_i     = s_i;
    assign dac_q     = s_q;
    assign dac_valid = dac_valid_q;
    assign tx_end    = tx_end_q;
`endif
endmodule

// File: tb/tb_tx_iq_rate_buf.sv
// Directed self-checking bench for tx_iq_rate_buf; covers TX_IQ_GAIN_EN when that macro is defined.
module tb_tx_iq_rate_buf;
`ifdef TX_IQ_GAIN_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        fs_a, fd_a, fs_b, fd_b;
    logic        dv_a, und_a, busy_a, te_a, dv_b, und_b, busy_b, te_b;
    logic [15:0] di_a, dq_a, di_b, dq_b;
    logic [9:0]  lvl_a, lvl_b;
    logic [7:0]  gain;
    int          checks = 0;
    int          errors = 0;

    tx_iq_rate_buf_if #(.DATA_W(16)) if_a ();
    tx_iq_rate_buf_if #(.DATA_W(16)) if_b ();

    always #5 clock = ~clock;

    tx_iq_rate_buf #(.DATA_W(16), .DEPTH_LOG2(9), .SAMPLE_DIV(10), .PREFILL(64)) dut_a (
        .clock(clock), .reset(reset), .frame_start(fs_a), .frame_done(fd_a), .iq(if_a),
        .dac_valid(dv_a), .dac_i(di_a), .dac_q(dq_a), .underrun(und_a), .busy(busy_a),
        .tx_end(te_a), .level(lvl_a)
`ifdef TX_IQ_GAIN_EN
        , .gain(gain)
`endif
    );

    tx_iq_rate_buf #(.DATA_W(16), .DEPTH_LOG2(9), .SAMPLE_DIV(10), .PREFILL(512)) dut_b (
        .clock(clock), .reset(reset), .frame_start(fs_b), .frame_done(fd_b), .iq(if_b),
        .dac_valid(dv_b), .dac_i(di_b), .dac_q(dq_b), .underrun(und_b), .busy(busy_b),
        .tx_end(te_b), .level(lvl_b)
`ifdef TX_IQ_GAIN_EN
        , .gain(gain)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        int bad = 0;
        reset = 1'b1; fs_a = 0; fd_a = 0; fs_b = 0; fd_b = 0; gain = 8'd128;
        if_a.iq_valid = 0; if_a.iq_i = '0; if_a.iq_q = '0;
        if_b.iq_valid = 0; if_b.iq_i = '0; if_b.iq_q = '0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (dv_a !== 1'b0) begin errors++; $display("FAIL reset_dac_valid got %b want 0", dv_a); end
        checks++; if (di_a !== 16'd0 || dq_a !== 16'd0) begin errors++; $display("FAIL reset_dac_iq got %0d/%0d want 0/0", di_a, dq_a); end
        checks++; if (if_a.iq_ready !== 1'b1) begin errors++; $display("FAIL reset_iq_ready got %b want 1", if_a.iq_ready); end
        checks++; if (lvl_a !== 10'd0) begin errors++; $display("FAIL reset_level got %0d want 0", lvl_a); end
        checks++; if (und_a !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", und_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
        checks++; if (te_a !== 1'b0) begin errors++; $display("FAIL reset_tx_end got %b want 0", te_a); end
        for (int c = 0; c < 100; c++) begin
            tick();
            if (dv_a !== 1'b0 || di_a !== 16'd0 || dq_a !== 16'd0 || if_a.iq_ready !== 1'b1 || lvl_a !== 10'd0)
                bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL idle_outputs bad_cycles got %0d want 0", bad); end
    endtask

    task automatic test_stream();
        int n_out = 0;
        int te_cnt = 0;
        int te_bad = 0;
        int exp_cyc;
        fs_a = 1'b1;
        for (int cyc = 1; cyc <= 2066 + LAT + 20; cyc++) begin
            tick();
            fs_a = 1'b0; fd_a = 1'b0;
            if (dv_a === 1'b1) begin
                n_out++;
                exp_cyc = 76 + 10 * (n_out - 1) + LAT - 1;
                checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL stream_time n=%0d got %0d want %0d", n_out, cyc, exp_cyc); end
                checks++; if (di_a !== 16'(n_out) || dq_a !== 16'(-n_out)) begin
                    errors++; $display("FAIL stream_data n=%0d got %0d/%0d want %0d/%0d", n_out, $signed(di_a), $signed(dq_a), n_out, -n_out);
                end
            end
            if (te_a === 1'b1) begin
                te_cnt++;
                if (!(dv_a === 1'b1 && n_out == 200)) te_bad++;
            end
            if (cyc <= 200) begin if_a.iq_valid = 1; if_a.iq_i = 16'(cyc); if_a.iq_q = 16'(-cyc); end
            else if_a.iq_valid = 0;
            if (cyc == 201) fd_a = 1'b1;
        end
        checks++; if (n_out !== 200) begin errors++; $display("FAIL stream_count got %0d want 200", n_out); end
        checks++; if (te_cnt !== 1 || te_bad !== 0) begin errors++; $display("FAIL stream_tx_end got %0d (misplaced %0d) want 1", te_cnt, te_bad); end
        checks++; if (busy_a !== 1'b0 || und_a !== 1'b0) begin errors++; $display("FAIL stream_end busy/underrun got %b/%b want 0/0", busy_a, und_a); end
        checks++; if (lvl_a !== 10'd0) begin errors++; $display("FAIL stream_end_level got %0d want 0", lvl_a); end
    endtask

    task automatic test_underrun();
        int n_in = 0;
        int n_out = 0;
        int zeros = 0;
        int gap_bad = 0;
        int te_bad = 0;
        int last_dv = 0;
        bit found = 0;
        fs_a = 1'b1;
        for (int cyc = 1; cyc <= 1900; cyc++) begin
            tick();
            fs_a = 1'b0;
            if (dv_a === 1'b1) begin
                if (last_dv > 0 && cyc - last_dv != 10) gap_bad++;
                last_dv = cyc;
                if (di_a !== 16'd0) begin
                    n_out++;
                    checks++; if (di_a !== 16'(n_out) || dq_a !== 16'(-n_out)) begin
                        errors++; $display("FAIL underrun_order got %0d/%0d want %0d/%0d", $signed(di_a), $signed(dq_a), n_out, -n_out);
                    end
                end else begin
                    zeros++;
                    checks++; if (dq_a !== 16'd0) begin errors++; $display("FAIL underrun_zero_q got %0d want 0", $signed(dq_a)); end
                end
            end
            if (te_a === 1'b1) te_bad++;
            if (cyc <= 64 || (cyc <= 64 + 1600 && (cyc - 64) % 20 == 0)) begin
                n_in++; if_a.iq_valid = 1; if_a.iq_i = 16'(n_in); if_a.iq_q = 16'(-n_in);
            end else if_a.iq_valid = 0;
        end
        checks++; if (n_out !== 144) begin errors++; $display("FAIL underrun_data_count got %0d want 144", n_out); end
        checks++; if (zeros == 0) begin errors++; $display("FAIL underrun_zero_count got %0d want >0", zeros); end
        checks++; if (gap_bad !== 0) begin errors++; $display("FAIL underrun_spacing bad got %0d want 0", gap_bad); end
        checks++; if (te_bad !== 0) begin errors++; $display("FAIL underrun_early_tx_end got %0d want 0", te_bad); end
        checks++; if (und_a !== 1'b1) begin errors++; $display("FAIL underrun_flag got %b want 1", und_a); end
        fd_a = 1'b1;
        for (int c = 0; c < 30 && !found; c++) begin
            tick();
            fd_a = 1'b0;
            if (te_a === 1'b1) begin
                found = 1;
                checks++; if (dv_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL underrun_end dv/busy got %b/%b want 0/0", dv_a, busy_a); end
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL underrun_tx_end got none want pulse"); end
    endtask

    task automatic test_short();
        int n_out = 0;
        int te_cnt = 0;
        int te_bad = 0;
        int exp_cyc;
        fs_a = 1'b1;
        for (int cyc = 1; cyc <= 113 + LAT + 15; cyc++) begin
            tick();
            fs_a = 1'b0; fd_a = 1'b0;
            if (dv_a === 1'b1) begin
                n_out++;
                exp_cyc = 23 + 10 * (n_out - 1) + LAT - 1;
                checks++; if (cyc !== exp_cyc || di_a !== 16'(n_out) || dq_a !== 16'(-n_out)) begin
                    errors++; $display("FAIL short_sample n=%0d got cyc %0d %0d/%0d want cyc %0d %0d/%0d", n_out, cyc, $signed(di_a), $signed(dq_a), exp_cyc, n_out, -n_out);
                end
            end
            if (te_a === 1'b1) begin
                te_cnt++;
                if (!(dv_a === 1'b1 && n_out == 10)) te_bad++;
            end
            if (cyc <= 10) begin if_a.iq_valid = 1; if_a.iq_i = 16'(cyc); if_a.iq_q = 16'(-cyc); end
            else if_a.iq_valid = 0;
            if (cyc == 11) fd_a = 1'b1;
        end
        checks++; if (n_out !== 10) begin errors++; $display("FAIL short_count got %0d want 10", n_out); end
        checks++; if (te_cnt !== 1 || te_bad !== 0) begin errors++; $display("FAIL short_tx_end got %0d (misplaced %0d) want 1", te_cnt, te_bad); end
        checks++; if (busy_a !== 1'b0 || und_a !== 1'b0) begin errors++; $display("FAIL short_end busy/underrun got %b/%b want 0/0", busy_a, und_a); end
    endtask

`ifdef TX_IQ_GAIN_EN
    task automatic test_gain();
        int g_tab[3]  = '{255, 64, 128};
        int i_tab[3]  = '{30000, -1001, 1234};
        int q_tab[3]  = '{-30000, 1001, -5};
        int ei_tab[3] = '{32767, -501, 1234};
        int eq_tab[3] = '{-32768, 500, -5};
        bit seen;
        for (int v = 0; v < 3; v++) begin
            gain = 8'(g_tab[v]);
            seen = 0;
            fs_a = 1'b1;
            tick();
            fs_a = 1'b0; if_a.iq_valid = 1; if_a.iq_i = 16'(i_tab[v]); if_a.iq_q = 16'(q_tab[v]);
            tick();
            if_a.iq_valid = 0; fd_a = 1'b1;
            for (int c = 0; c < 40; c++) begin
                tick();
                fd_a = 1'b0;
                if (dv_a === 1'b1 && !seen) begin
                    seen = 1;
                    checks++; if (di_a !== 16'(ei_tab[v]) || dq_a !== 16'(eq_tab[v])) begin
                        errors++; $display("FAIL gain_%0d got %0d/%0d want %0d/%0d", g_tab[v], $signed(di_a), $signed(dq_a), ei_tab[v], eq_tab[v]);
                    end
                end
            end
            checks++; if (!seen) begin errors++; $display("FAIL gain_%0d_valid got none want pulse", g_tab[v]); end
        end
        gain = 8'd128;
    endtask
`endif

    task automatic test_full();
        int n = 1;
        int acc = 0;
        bit pend = 0;
        bit seen = 0;
        fs_b = 1'b1;
        for (int cyc = 1; cyc <= 530; cyc++) begin
            tick();
            fs_b = 1'b0;
            if (pend) begin acc++; n++; end
            if_b.iq_valid = 1; if_b.iq_i = 16'(n); if_b.iq_q = 16'(-n);
            pend = if_b.iq_ready;
            if (cyc == 513) begin
                checks++; if (lvl_b !== 10'd512) begin errors++; $display("FAIL full_level got %0d want 512", lvl_b); end
                checks++; if (if_b.iq_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", if_b.iq_ready); end
            end
            if (cyc == 523) begin
                checks++; if (acc !== 512 || lvl_b !== 10'd512) begin errors++; $display("FAIL full_hold acc/level got %0d/%0d want 512/512", acc, lvl_b); end
            end
            if (dv_b === 1'b1 && !seen) begin
                seen = 1;
                checks++; if (cyc !== 524 + LAT - 1 || di_b !== 16'd1) begin
                    errors++; $display("FAIL full_first_out got cyc %0d val %0d want cyc %0d val 1", cyc, $signed(di_b), 524 + LAT - 1);
                end
            end
            if (cyc == 526) begin
                checks++; if (acc !== 513 || lvl_b !== 10'd512) begin errors++; $display("FAIL full_refill acc/level got %0d/%0d want 513/512", acc, lvl_b); end
            end
        end
        if_b.iq_valid = 0;
        checks++; if (!seen) begin errors++; $display("FAIL full_stream got none want pulse"); end
    endtask

    task automatic test_midreset();
        int pulses = 0;
        int bad = 0;
        fs_a = 1'b1;
        for (int cyc = 1; cyc <= 300 && pulses < 3; cyc++) begin
            tick();
            fs_a = 1'b0;
            if (dv_a === 1'b1) pulses++;
            if (cyc <= 100) begin if_a.iq_valid = 1; if_a.iq_i = 16'(cyc); if_a.iq_q = 16'(-cyc); end
            else if_a.iq_valid = 0;
        end
        checks++; if (pulses !== 3) begin errors++; $display("FAIL midreset_stream pulses got %0d want 3", pulses); end
        reset = 1'b1; if_a.iq_valid = 0;
        tick();
        reset = 1'b0;
        checks++; if (dv_a !== 1'b0 || te_a !== 1'b0) begin errors++; $display("FAIL midreset_dv_te got %b/%b want 0/0", dv_a, te_a); end
        checks++; if (di_a !== 16'd0 || dq_a !== 16'd0) begin errors++; $display("FAIL midreset_dac got %0d/%0d want 0/0", di_a, dq_a); end
        checks++; if (lvl_a !== 10'd0 || if_a.iq_ready !== 1'b1) begin errors++; $display("FAIL midreset_fifo level/ready got %0d/%b want 0/1", lvl_a, if_a.iq_ready); end
        checks++; if (busy_a !== 1'b0 || und_a !== 1'b0) begin errors++; $display("FAIL midreset_busy_und got %b/%b want 0/0", busy_a, und_a); end
        checks++; if (lvl_b !== 10'd0 || busy_b !== 1'b0) begin errors++; $display("FAIL midreset_b level/busy got %0d/%b want 0/0", lvl_b, busy_b); end
        for (int c = 0; c < 30; c++) begin
            tick();
            if (dv_a !== 1'b0 || te_a !== 1'b0 || busy_a !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL midreset_quiet bad_cycles got %0d want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_underrun();
        test_short();
`ifdef TX_IQ_GAIN_EN
        test_gain();
`endif
        test_full();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
